bit_serial_alu_ctrl: RTL and testbench

// Sequences one ALU_bit_slice across a WIDTH-bit operand pair, one bit per cycle, LSB first.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/ALU_bit_slice.sv | 34 +++
 rtl/bit_serial_alu_ctrl.sv | 108 ++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and controller state type shared by the parallel and bit-serial ALUs.
package alu_pkg;

   localparam logic [2:0] HOLD_B_CODE = 3'b000;
   localparam logic [2:0] RSVD1_CODE  = 3'b001;
   localparam logic [2:0] ADD_CODE    = 3'b010;
   localparam logic [2:0] SUB_CODE    = 3'b011;
   localparam logic [2:0] AND_CODE    = 3'b100;
   localparam logic [2:0] OR_CODE     = 3'b101;
   localparam logic [2:0] XOR_CODE    = 3'b110;
   localparam logic [2:0] RSVD7_CODE  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return op[2:1] == 2'b01;
   endfunction

endpackage

// File: rtl/ALU_bit_slice.sv
// One-bit ALU slice: combinational result bit and carry for a single bit position.
module ALU_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       carry_in,
   input  logic [2:0] op_select,
   output logic       alu_bit,
   output logic       carry_out
);

   logic w_b_eff;

   // SUB inverts B; the +1 arrives as the initial carry from the controller.
   assign w_b_eff = b ^ op_select[0];

   always_comb begin
      alu_bit   = 1'b0;
      carry_out = 1'b0;
      case (op_select)
         ADD_CODE, SUB_CODE: begin
            alu_bit   = a ^ w_b_eff ^ carry_in;
            carry_out = (a & w_b_eff) | (carry_in & (a ^ w_b_eff));
         end
         AND_CODE:    alu_bit = a & b;
         OR_CODE:     alu_bit = a | b;
         XOR_CODE:    alu_bit = a ^ b;
         HOLD_B_CODE: alu_bit = b;
         default:     alu_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU controller: walks one ALU_bit_slice across WIDTH bits, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module bit_serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   ctrl_state_t      r_state;
   ctrl_state_t      w_state_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_result;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_c_msb_in;
   logic             w_bit;
   logic             w_slice_cout;
   logic             w_done;

   ALU_bit_slice u_slice (
      .a         (r_a_sh[0]),
      .b         (r_b_sh[0]),
      .carry_in  (r_carry),
      .op_select (r_op),
      .alu_bit   (w_bit),
      .carry_out (w_slice_cout)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_next = RUN;
         RUN:     if (r_cnt == LAST_BIT) w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_result   <= '0;
         r_op       <= HOLD_B_CODE;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_c_msb_in <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a_sh   <= A;
               r_b_sh   <= B;
               r_op     <= op_select;
               r_result <= '0;
               r_cnt    <= '0;
               r_carry  <= (op_select == SUB_CODE);
            end
            RUN: begin
               r_result <= {w_bit, r_result[WIDTH-1:1]};
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_carry  <= w_slice_cout;
               r_cnt    <= r_cnt + CW'(1);
               // Carry into the MSB, kept for the signed-overflow test.
               if (r_cnt == LAST_BIT) r_c_msb_in <= r_carry;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_done    = (r_state == DONE);
      in_ready  = (r_state == IDLE);
      out_valid = w_done;
      result    = w_done ? r_result : '0;
      negative  = w_done & r_result[WIDTH-1];
      zero      = w_done & (r_result == '0);
      carry_out = w_done & is_arith(r_op) & r_carry;
      overflow  = w_done & is_arith(r_op) & (r_carry ^ r_c_msb_in);
   end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl at WIDTH=64: directed table, random ops
// against an arithmetic reference model, back-to-back throughput and mid-run reset.
module tb_bit_serial_alu_ctrl;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   op_select;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         negative;
   logic         zero;
   logic         overflow;
   logic         carry_out;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         n;
      logic         z;
      logic         v;
      logic         c;
   } vec_t;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op_select (op_select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .negative  (negative),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic, flags from sign rules.
   function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t        e;
      logic [W:0]  full;
      e.op = op; e.a = a; e.b = b; e.r = '0; e.v = 1'b0; e.c = 1'b0;
      case (op)
         3'b010: begin
            full = {1'b0, a} + {1'b0, b};
            e.r = full[W-1:0]; e.c = full[W];
            e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
         end
         3'b011: begin
            full = {1'b0, a} + {1'b0, ~b} + 65'd1;
            e.r = full[W-1:0]; e.c = full[W];
            e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
         end
         3'b100:  e.r = a & b;
         3'b101:  e.r = a | b;
         3'b110:  e.r = a ^ b;
         3'b000:  e.r = b;
         default: e.r = '0;
      endcase
      e.n = e.r[W-1];
      e.z = (e.r == '0);
      return e;
   endfunction

   function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] r, input logic n, input logic z,
                               input logic v, input logic c);
      vec_t e;
      e.op = op; e.a = a; e.b = b; e.r = r; e.n = n; e.z = z; e.v = v; e.c = c;
      return e;
   endfunction

   task automatic check_out(input string tag, input vec_t e);
      chk({tag, ".result"},    result,    e.r);
      chk({tag, ".negative"},  W'(negative),  W'(e.n));
      chk({tag, ".zero"},      W'(zero),      W'(e.z));
      chk({tag, ".overflow"},  W'(overflow),  W'(e.v));
      chk({tag, ".carry_out"}, W'(carry_out), W'(e.c));
   endtask

   // One full transaction; optionally holds out_ready low and pokes in_valid during RUN.
   task automatic run_op(input string tag, input vec_t e, input int hold, input bit poke_run);
      int cyc;
      @(negedge clk);
      A = e.a; B = e.b; op_select = e.op; in_valid = 1'b1; out_ready = 1'b0;
      chk({tag, ".in_ready_idle"}, W'(in_ready), W'(1));
      @(negedge clk);
      cyc = 1;
      in_valid = poke_run;
      if (poke_run) begin
         A = {$urandom, $urandom}; B = {$urandom, $urandom}; op_select = 3'b010;
         chk({tag, ".in_ready_run"}, W'(in_ready), W'(0));
      end
      while (!out_valid && cyc < W + 8) begin
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, W'(cyc), W'(W + 1));
      check_out(tag, e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, ".hold_valid"},  W'(out_valid), W'(1));
         chk({tag, ".hold_ready"},  W'(in_ready),  W'(0));
         chk({tag, ".hold_result"}, result,        e.r);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".valid_drop"}, W'(out_valid), W'(0));
      chk({tag, ".ready_back"}, W'(in_ready),  W'(1));
      $display("op=%0b A=0x%0h B=0x%0h result=0x%0h n=%0b z=%0b v=%0b c=%0b",
               e.op, e.a, e.b, e.r, e.n, e.z, e.v, e.c);
   endtask

   vec_t tbl [12];
   vec_t q [$];

   initial begin
      vec_t e;
      int   cyc, acc, last_acc, seen;

      tbl[0]  = mk(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1, 0, 1, 0);
      tbl[1]  = mk(3'b011, 64'd5, 64'd5, 64'd0, 0, 1, 0, 1);
      tbl[2]  = mk(3'b011, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
      tbl[3]  = mk(3'b100, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0, 0);
      tbl[4]  = mk(3'b101, 64'hF0F0, 64'hFF00, 64'hFFF0, 0, 0, 0, 0);
      tbl[5]  = mk(3'b110, 64'hF0F0, 64'hFF00, 64'h0FF0, 0, 0, 0, 0);
      tbl[6]  = mk(3'b000, 64'hF0F0, 64'hFF00, 64'hFF00, 0, 0, 0, 0);
      tbl[7]  = mk(3'b111, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FFFF_0001, 64'd0, 0, 1, 0, 0);
      tbl[8]  = mk(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'd0, 0, 1, 0, 0);
      tbl[9]  = mk(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1, 0, 1);
      tbl[10] = mk(3'b011, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
      tbl[11] = mk(3'b010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 0, 1, 1, 1);

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op_select = 3'b000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset.in_ready",  W'(in_ready),  W'(1));
      chk("reset.out_valid", W'(out_valid), W'(0));
      e = mk(3'b000, '0, '0, '0, 0, 0, 0, 0);
      check_out("reset", e);

      for (int i = 0; i < 12; i++)
         run_op($sformatf("tbl%0d", i), tbl[i], (i == 0) ? 5 : 0, i == 0);

      for (int i = 0; i < 30; i++) begin
         e = model(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
         run_op($sformatf("rnd%0d", i), e, i % 3, i % 4 == 1);
      end

      // Back-to-back: operands change every cycle, only accept-cycle values count.
      cyc = 0; acc = 0; last_acc = -1;
      out_ready = 1'b1;
      while ((acc < 3 || q.size() > 0) && cyc < 4 * (W + 2) + 20) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            if (q.size() == 0) chk("b2b.unexpected", W'(1), W'(0));
            else begin
               e = q.pop_front();
               check_out("b2b", e);
               $display("b2b op=%0b A=0x%0h B=0x%0h result=0x%0h", e.op, e.a, e.b, result);
            end
         end
         if (acc < 3) begin
            A = {$urandom, $urandom}; B = {$urandom, $urandom};
            op_select = 3'($urandom_range(0, 6));
            in_valid = 1'b1;
         end else in_valid = 1'b0;
         if (in_valid && in_ready) begin
            q.push_back(model(op_select, A, B));
            if (last_acc >= 0) chk("b2b.spacing", W'(cyc - last_acc), W'(W + 2));
            last_acc = cyc;
            acc++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b.accepts", W'(acc), W'(3));
      chk("b2b.drained", W'(q.size()), W'(0));

      // Reset while the slice is on bit 10.
      @(negedge clk);
      A = 64'hFFFF_0000_FFFF_0000; B = 64'h1111; op_select = 3'b010; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_run.in_ready",  W'(in_ready),  W'(1));
      chk("rst_run.out_valid", W'(out_valid), W'(0));
      e = mk(3'b000, '0, '0, '0, 0, 0, 0, 0);
      check_out("rst_run", e);
      seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("rst_run.no_pulse", W'(seen), W'(0));
      $display("reset mid-run at bit 10: discarded");
      run_op("after_rst", mk(3'b010, 64'd3, 64'd4, 64'd7, 0, 0, 0, 0), 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
